// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter for the core's data-memory port.
// Firmware stores bytes into TXDATA. They queue in a small FIFO. A serializer
// drains the FIFO onto o_tx, least significant bit first. It inserts no idle
// gap between frames while bytes are waiting.
//
// Register window (word offsets from BASE_ADDR; byte lanes are ignored):
//   +0x0 TXDATA  write pushes i_wr_data[7:0]; reads 0
//   +0x4 STATUS  read: bit0 busy, bit1 full, bit2 empty, bit3 overflow,
//                bits[15:8] FIFO count
//                write: a 1 in bit3 clears the sticky overflow flag
//   +0x8 CTRL    bit0 irq_en (only with MMIO_UART_TX_IRQ_EN defined)
//   +0xC         unmapped, o_sel is 0
//
// Optional feature macro: MMIO_UART_TX_IRQ_EN
//   When it is defined, CTRL.irq_en exists and o_irq = irq_en & empty & ~busy
//   (registered).
//   When it is undefined, CTRL reads 0 and o_irq is tied low.
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_clk_en   core clock-enable; bus writes are accepted only while it is high
//   i_addr     byte address from the memory stage
//   i_wr_en    store strobe
//   i_wr_data  store data
//   i_rd_en    load strobe
//   o_sel      combinational window hit (offsets 0x0..0x8)
//   o_rd_data  combinational load data; 0 when there is no read hit
//   o_tx       registered serial line, idle high
//   o_irq      registered interrupt request
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clk_en,
   input  logic [31:0] i_addr,
   input  logic        i_wr_en,
   input  logic [31:0] i_wr_data,
   input  logic        i_rd_en,
   output logic        o_sel,
   output logic [31:0] o_rd_data,
   output logic        o_tx,
   output logic        o_irq
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } txState_t;

   txState_t          state;
   txState_t          stateNext;
   logic [1:0]        regOffset;
   logic              wrAccept;
   logic              pushReq;
   logic              statusWr;
   logic              pushNow;
   logic              popNow;
   logic [7:0]        fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [CNT_W-1:0]  fifoCount;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              overflow;
   logic              overflowSet;
   logic              overflowClr;
   logic [BAUD_W-1:0] baudCnt;
   logic              baudDone;
   logic [2:0]        bitIdx;
   logic [7:0]        shiftReg;
   logic [7:0]        shiftNext;
   logic              txNext;
   logic              busy;
   logic [31:0]       statusWord;
   logic [31:0]       ctrlWord;
   logic              unusedBits;

   // Address decode: the window covers four words, and the fourth is left unmapped.
   // A write takes effect only if the core's clock-enable is high in that cycle.
   assign regOffset   = i_addr[3:2];
   assign o_sel       = (i_addr[31:4] == BASE_ADDR[31:4]) && (regOffset != 2'd3);
   assign wrAccept    = i_clk_en && i_wr_en && o_sel;
   assign pushReq     = wrAccept && (regOffset == 2'd0);
   assign statusWr    = wrAccept && (regOffset == 2'd1);
   assign unusedBits  = ^{i_addr[1:0], i_wr_data[31:8]};

   // A push into a full FIFO still succeeds if the serializer pops in the same
   // cycle. Only a push that truly has no free slot is dropped and flagged.
   assign fifoFull    = (fifoCount == CNT_W'(FIFO_DEPTH));
   assign fifoEmpty   = (fifoCount == '0);
   assign pushNow     = pushReq && (!fifoFull || popNow);
   assign overflowSet = pushReq && fifoFull && !popNow;
   assign overflowClr = statusWr && i_wr_data[3];
   assign busy        = (state != ST_IDLE);
   assign baudDone    = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));

   // FIFO storage holds no control state, so it needs no reset. A stale entry
   // is never read because the count gates every pop.
   always_ff @(posedge i_clk) begin
      if (pushNow) begin
         fifoMem[wrPtr] <= i_wr_data[7:0];
      end
   end

   // FIFO pointers and occupancy. The depth is a power of two, so the pointers
   // wrap naturally. A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (pushNow) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (popNow) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         case ({pushNow, popNow})
            2'b10:   fifoCount <= fifoCount + CNT_W'(1);
            2'b01:   fifoCount <= fifoCount - CNT_W'(1);
            default: fifoCount <= fifoCount;
         endcase
      end
   end

   // Sticky overflow flag. If firmware clears it in the same cycle that a byte
   // is dropped, the drop must stay visible, so the set takes priority.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         overflow <= 1'b0;
      end else if (overflowSet) begin
         overflow <= 1'b1;
      end else if (overflowClr) begin
         overflow <= 1'b0;
      end
   end

   // Serializer next-state logic. Bytes are popped both from IDLE and at the
   // end of a stop bit, which is what makes queued frames contiguous. The
   // shift register loads at the moment of a pop and shifts once per data bit.
   always_comb begin
      stateNext = state;
      popNow    = 1'b0;
      shiftNext = shiftReg;
      case (state)
         ST_IDLE: begin
            if (!fifoEmpty) begin
               popNow    = 1'b1;
               stateNext = ST_START;
            end
         end
         ST_START: begin
            if (baudDone) begin
               stateNext = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baudDone) begin
               shiftNext = {1'b0, shiftReg[7:1]};
               if (bitIdx == 3'd7) begin
                  stateNext = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (baudDone) begin
               if (!fifoEmpty) begin
                  popNow    = 1'b1;
                  stateNext = ST_START;
               end else begin
                  stateNext = ST_IDLE;
               end
            end
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
      if (popNow) begin
         shiftNext = fifoMem[rdPtr];
      end
   end

   // The line level is derived from the state being entered. Registering it
   // then puts the start bit on o_tx in the same cycle that START begins.
   always_comb begin
      txNext = 1'b1;
      case (stateNext)
         ST_START: txNext = 1'b0;
         ST_DATA:  txNext = shiftNext[0];
         default:  txNext = 1'b1;
      endcase
   end

   // Serializer registers. The baud counter restarts on every state entry and
   // after each completed bit period. The bit index saturates at 7.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         baudCnt  <= '0;
         bitIdx   <= 3'd0;
         shiftReg <= 8'd0;
         o_tx     <= 1'b1;
      end else begin
         state    <= stateNext;
         shiftReg <= shiftNext;
         o_tx     <= txNext;
         if ((stateNext != state) || baudDone) begin
            baudCnt <= '0;
         end else if (state != ST_IDLE) begin
            baudCnt <= baudCnt + BAUD_W'(1);
         end
         if ((state == ST_START) && (stateNext == ST_DATA)) begin
            bitIdx <= 3'd0;
         end else if ((state == ST_DATA) && baudDone && (bitIdx != 3'd7)) begin
            bitIdx <= bitIdx + 3'd1;
         end
      end
   end

`ifdef MMIO_UART_TX_IRQ_EN
   logic irqEn;

   // The interrupt asks for more data. It is raised when the transmitter has
   // drained completely, and it is registered from the state at the previous edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         irqEn <= 1'b0;
         o_irq <= 1'b0;
      end else begin
         if (wrAccept && (regOffset == 2'd2)) begin
            irqEn <= i_wr_data[0];
         end
         o_irq <= irqEn && fifoEmpty && !busy;
      end
   end

   assign ctrlWord = {31'd0, irqEn};
`else
   assign ctrlWord = 32'd0;
   assign o_irq    = 1'b0;
`endif

   // Load data is purely combinational, so a STATUS read returns the state
   // registered at the preceding edge within the single-cycle memory stage.
   assign statusWord = (32'(fifoCount) << 8) | {28'd0, overflow, fifoEmpty, fifoFull, busy};

   always_comb begin
      o_rd_data = 32'd0;
      if (i_rd_en && o_sel) begin
         case (regOffset)
            2'd1:    o_rd_data = statusWord;
            2'd2:    o_rd_data = ctrlWord;
            default: o_rd_data = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
// Self-checking bench for mmio_uart_tx, with CLKS_PER_BIT=4 and FIFO_DEPTH=8.
// The reference model keeps the bytes queued by firmware and the start time
// of the frame in flight. From these it computes the expected line level
// directly from the frame bit position. It also computes the expected STATUS
// and CTRL words, o_sel and o_irq. A compare process checks the model against
// the DUT on every cycle. Directed steps add hand-computed literal expectations.
// Define MMIO_UART_TX_IRQ_EN to include the interrupt checks.
module tb_mmio_uart_tx;

   localparam int          CPB  = 4;
   localparam int          FD   = 8;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] A_TX   = BASE + 32'h0;
   localparam logic [31:0] A_STAT = BASE + 32'h4;
   localparam logic [31:0] A_CTRL = BASE + 32'h8;
   localparam logic [31:0] A_HOLE = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rst;
   logic        clkEn;
   logic [31:0] addr;
   logic        wrEn;
   logic [31:0] wrData;
   logic        rdEn;
   logic        sel;
   logic [31:0] rdData;
   logic        tx;
   logic        irq;

   int compared   = 0;
   int mismatched = 0;
   bit checkEn    = 1'b0;

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (FD)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_clk_en  (clkEn),
      .i_addr    (addr),
      .i_wr_en   (wrEn),
      .i_wr_data (wrData),
      .i_rd_en   (rdEn),
      .o_sel     (sel),
      .o_rd_data (rdData),
      .o_tx      (tx),
      .o_irq     (irq)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Reference model state.
   logic [7:0] mQueue[$];
   bit         mActive   = 1'b0;
   int         mStart    = 0;
   logic [7:0] mByte     = 8'd0;
   bit         mOverflow = 1'b0;
   bit         mIrqEn    = 1'b0;
   bit         mIrq      = 1'b0;
   int         cyc       = 0;

   function automatic bit modelSel(input logic [31:0] a);
      return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'd3);
   endfunction

   function automatic logic modelTx();
      logic [9:0] frameBits;
      int         k;
      if (!mActive) return 1'b1;
      frameBits = {1'b1, mByte, 1'b0};
      k = (cyc - mStart) / CPB;
      return frameBits[k];
   endfunction

   function automatic logic [31:0] modelStatus();
      logic [31:0] s;
      s = 32'(mQueue.size()) << 8;
      s[0] = mActive;
      s[1] = (mQueue.size() == FD);
      s[2] = (mQueue.size() == 0);
      s[3] = mOverflow;
      return s;
   endfunction

   function automatic logic [31:0] modelRead();
      if (!(rdEn && modelSel(addr))) return 32'd0;
      case (addr[3:2])
         2'd1:    return modelStatus();
`ifdef MMIO_UART_TX_IRQ_EN
         2'd2:    return {31'd0, mIrqEn};
`endif
         default: return 32'd0;
      endcase
   endfunction

   // The model advances at each rising edge using the inputs applied before
   // it. A frame lasts 10*CPB cycles from the edge at which its byte leaves the
   // queue. A byte leaves only when no frame is in flight at that edge. The
   // occupancy used to judge fullness is the occupancy before this edge's pop.
   always @(posedge clk) begin
      int  sizeBefore;
      bit  popped;
      bit  accept;
      cyc = cyc + 1;
      if (rst) begin
         mQueue.delete();
         mActive   = 1'b0;
         mOverflow = 1'b0;
         mIrqEn    = 1'b0;
         mIrq      = 1'b0;
      end else begin
         sizeBefore = mQueue.size();
         mIrq   = mIrqEn && (sizeBefore == 0) && !mActive;
         popped = 1'b0;
         if (mActive && (cyc - mStart == 10 * CPB)) mActive = 1'b0;
         if (!mActive && sizeBefore > 0) begin
            mByte   = mQueue.pop_front();
            mStart  = cyc;
            mActive = 1'b1;
            popped  = 1'b1;
         end
         accept = clkEn && wrEn && modelSel(addr);
         if (accept && addr[3:2] == 2'd0) begin
            if (sizeBefore == FD && !popped) mOverflow = 1'b1;
            else mQueue.push_back(wrData[7:0]);
         end
         if (accept && addr[3:2] == 2'd1 && wrData[3]) mOverflow = 1'b0;
`ifdef MMIO_UART_TX_IRQ_EN
         if (accept && addr[3:2] == 2'd2) mIrqEn = wrData[0];
`endif
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
                  name, cyc, actual, expected);
      end
   endtask

   // Compare the DUT against the model once per cycle, on the falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         logic expIrq;
`ifdef MMIO_UART_TX_IRQ_EN
         expIrq = mIrq;
`else
         expIrq = 1'b0;
`endif
         checkOutput("model_tx",    {31'd0, tx},  {31'd0, modelTx()});
         checkOutput("model_irq",   {31'd0, irq}, {31'd0, expIrq});
         checkOutput("model_sel",   {31'd0, sel}, {31'd0, modelSel(addr)});
         checkOutput("model_rdata", rdData,       modelRead());
      end
   end

   // Drive a set of bus inputs for exactly one rising edge.
   // The task returns 1 ns after that edge.
   task automatic applyStimulus(input logic [31:0] a, input logic we,
                                input logic [31:0] d, input logic re,
                                input logic ce);
      addr   = a;
      wrEn   = we;
      wrData = d;
      rdEn   = re;
      clkEn  = ce;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(A_STAT, 1'b0, 32'd0, 1'b1, 1'b1);
   endtask

   task automatic readReg(input string name, input logic [31:0] a,
                          input logic [31:0] expected);
      addr = a;
      wrEn = 1'b0;
      rdEn = 1'b1;
      #1;
      checkOutput(name, rdData, expected);
   endtask

   // Stop the run if it has not finished within a generous time limit.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [9:0] pat;
      rst    = 1'b1;
      clkEn  = 1'b1;
      addr   = A_STAT;
      wrEn   = 1'b0;
      wrData = 32'd0;
      rdEn   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst     = 1'b0;
      checkEn = 1'b1;

      $display("[TB] reset and idle");
      idle(20);
      checkOutput("idle_tx",  {31'd0, tx},  32'd1);
      checkOutput("idle_irq", {31'd0, irq}, 32'd0);
      readReg("idle_status", A_STAT, 32'h0000_0004);

      $display("[TB] single frame 0x55");
      applyStimulus(A_TX, 1'b1, 32'h0000_0055, 1'b0, 1'b1);
      idle(1);
      pat = {1'b1, 8'h55, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < CPB; j++) begin
            checkOutput("frame55_bit", {31'd0, tx}, {31'd0, pat[k]});
            if (k == 5 && j == 0) readReg("frame55_busy", A_STAT, 32'h0000_0005);
            idle(1);
         end
      end
      readReg("frame55_done", A_STAT, 32'h0000_0004);

      $display("[TB] back-to-back frames 0xA5, 0x3C");
      applyStimulus(A_TX, 1'b1, 32'h0000_00A5, 1'b0, 1'b1);
      applyStimulus(A_TX, 1'b1, 32'h0000_003C, 1'b0, 1'b1);
      idle(39);
      checkOutput("b2b_stop", {31'd0, tx}, 32'd1);
      idle(1);
      checkOutput("b2b_start", {31'd0, tx}, 32'd0);
      idle(45);

      $display("[TB] overflow");
      applyStimulus(A_TX, 1'b1, 32'h0000_0011, 1'b0, 1'b1);
      idle(3);
      for (int i = 0; i < 9; i++) applyStimulus(A_TX, 1'b1, 32'h20 + i, 1'b0, 1'b1);
      readReg("ovf_status", A_STAT, 32'h0000_080B);
      applyStimulus(A_STAT, 1'b1, 32'h0000_0008, 1'b0, 1'b1);
      readReg("ovf_cleared", A_STAT, 32'h0000_0803);
      idle(9 * 10 * CPB + 10);
      readReg("ovf_drained", A_STAT, 32'h0000_0004);

      $display("[TB] ignored writes");
      applyStimulus(A_TX, 1'b1, 32'h0000_0077, 1'b0, 1'b0);
      addr = A_HOLE;
      #1;
      checkOutput("hole_sel", {31'd0, sel}, 32'd0);
      applyStimulus(A_HOLE, 1'b1, 32'h0000_0066, 1'b1, 1'b1);
      idle(50);
      checkOutput("ignored_tx", {31'd0, tx}, 32'd1);
      readReg("ignored_status", A_STAT, 32'h0000_0004);

`ifdef MMIO_UART_TX_IRQ_EN
      $display("[TB] interrupt");
      applyStimulus(A_CTRL, 1'b1, 32'h0000_0001, 1'b0, 1'b1);
      idle(1);
      checkOutput("irq_set", {31'd0, irq}, 32'd1);
      readReg("ctrl_read", A_CTRL, 32'h0000_0001);
      applyStimulus(A_TX, 1'b1, 32'h0000_0042, 1'b0, 1'b1);
      idle(1);
      checkOutput("irq_push", {31'd0, irq}, 32'd0);
      idle(50);
      checkOutput("irq_again", {31'd0, irq}, 32'd1);
`else
      readReg("ctrl_read", A_CTRL, 32'h0000_0000);
`endif

      $display("[TB] reset mid-frame");
      applyStimulus(A_TX, 1'b1, 32'h0000_0099, 1'b0, 1'b1);
      applyStimulus(A_TX, 1'b1, 32'h0000_005A, 1'b0, 1'b1);
      applyStimulus(A_TX, 1'b1, 32'h0000_00C3, 1'b0, 1'b1);
      idle(8);
      rst = 1'b1;
      idle(1);
      checkOutput("rst_tx",  {31'd0, tx},  32'd1);
      checkOutput("rst_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;
      idle(60);
      checkOutput("rst_quiet_tx", {31'd0, tx}, 32'd1);
      readReg("rst_status", A_STAT, 32'h0000_0004);

      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds to data-memory loads and stores issued by the pipeline's memory stage. The core pushes bytes into an internal FIFO through a small register window; an 8N1 serializer drains the FIFO onto `o_tx`. It is the responder on the data-bus port the core initiates, and gives firmware a console output path.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: word-aligned base of the 3-register window.
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit, ≥ 2. The default gives 115200 baud at 100 MHz.
- `FIFO_DEPTH`, default 8: number of TX FIFO entries. Must be a power of 2, ≥ 2.

- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_clk_en`  in  1  core clock-enable. Bus writes are accepted only when this is 1. The serializer runs every cycle.
- `i_addr`  in  32  byte address from the memory stage.
- `i_wr_en`  in  1  store strobe.
- `i_wr_data`  in  32  store data.
- `i_rd_en`  in  1  load strobe.
- `o_sel`  out  1  combinational; 1 when `i_addr[31:4] == BASE_ADDR[31:4]` and `i_addr[3:2] != 3`.
- `o_rd_data`  out  32  combinational read data. It is 0 when there is no read, or no hit.
- `o_tx`  out  1  registered serial line, idle high.
- `o_irq`  out  1  registered interrupt request.

## Operation
- Register map, word offsets, byte lanes ignored:
  - +0x0 TXDATA
    - Write: pushes `i_wr_data[7:0]`.
    - Read: returns 0.
  - +0x4 STATUS, read:
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[15:8] FIFO count
    - all other bits 0
  - +0x4 STATUS, write: a 1 in bit3 clears overflow. Other bits are ignored.
  - +0x8 CTRL: bit0 `irq_en` (see Configuration). Other bits read 0.
  - +0xC: unmapped. `o_sel` is 0.
- Write accepted = `i_clk_en & i_wr_en & o_sel`. Effect is at that posedge.
- Push while full and no pop in the same cycle: byte dropped, overflow set to 1. The FIFO is unchanged.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - This also holds when the FIFO is full: the pop frees the slot.
- Overflow set and overflow clear in the same cycle: set wins.
- Serializer FSM:
  - IDLE (`o_tx`=1): if FIFO not empty → pop, load shift register, go to START.
  - START (`o_tx`=0) for CLKS_PER_BIT cycles → DATA with bit index 0.
  - DATA (`o_tx`=shift[0], LSB first): each CLKS_PER_BIT cycles shift right. After index 7 → STOP.
  - STOP (`o_tx`=1) for CLKS_PER_BIT cycles. At the end: FIFO not empty → pop, go to START (no idle gap); else → IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and is cleared on every state entry. Bit index is 3 bits and does not wrap.
- Reset values:
  - `o_tx`=1, `o_irq`=0
  - FSM IDLE, FIFO empty, count 0
  - overflow 0, `irq_en` 0
  - FIFO contents don't-care
- Reset mid-frame: line returns high on the next cycle and pending bytes are discarded.

## Timing
- Write at edge N into an empty FIFO with FSM IDLE:
  - FIFO count is 1 after N.
  - Pop at N+1; `o_tx` falls after N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- STATUS read reflects state registered at the preceding edge. It is combinational with no added latency, matching the single-cycle memory-stage load.
- `o_irq` updates one cycle after its condition changes.

## Configuration
- `MMIO_UART_TX_IRQ_EN` defined:
  - CTRL.`irq_en` is writable and readable.
  - `o_irq` is registered as `irq_en & empty & ~busy`. It is level-sensitive and clears when a byte is pushed (one cycle later).
- Undefined:
  - CTRL reads 0 and writes are ignored.
  - `o_irq` is constant 0 and no `irq_en` flop is built.

## Test plan
- Reset, then idle 20 cycles:
  - `o_tx`=1, `o_irq`=0.
  - STATUS read = 0x0000_0004.
- CLKS_PER_BIT=4; write 0x55 to TXDATA:
  - `o_tx` = 0, 1,0,1,0,1,0,1,0, 1, each held 4 cycles.
  - Start bit begins 1 cycle after the write edge.
  - STATUS busy=1 throughout, then reads 0x04.
- Write 0xA5 and 0x3C on consecutive cycles: the two 40-cycle frames are contiguous, with no high gap between the first stop bit and the second start bit.
- FIFO_DEPTH=8; 9 writes while `i_clk_en`=1 during a frame:
  - STATUS overflow=1, count=8 after the last of the 9 writes.
  - The 9th byte is never transmitted.
  - Writing 0x8 to STATUS clears overflow.
- Write with `i_clk_en`=0, and write to +0xC: no push occurs, `o_sel`=0 for +0xC, and `o_tx` stays 1.
- With the macro defined:
  - Set `irq_en`=1 while FIFO is empty and FSM is IDLE → `o_irq`=1 after 1 cycle.
  - Push a byte → `o_irq`=0.
  - After the frame ends → `o_irq`=1 again.
  - Assert `i_rst` mid-frame → `o_tx`=1 and `o_irq`=0 next cycle.
